ula_mult_seq: RTL and testbench
===============================

ULA_MULT_SEQ -- requirements
Module: ula_mult_seq

Interface
REQ-001 Parameter: W, 4, operand width in bits; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 op  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 PASSA.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 busy  output  1  high while an operation is executing; start ignored while high.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  2W  operation result, held until the next operation completes.
REQ-011 cflag  output  1  ADD carry-out / SUB borrow / MUL and PASSA always 0.
REQ-012 zflag  output  1  high when result equals zero; updated with result.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, EXEC, DONE.
REQ-014 Accept: start=1 in IDLE or DONE SHALL latch a, b, op and enter EXEC; busy SHALL be high exactly in EXEC.
REQ-015 start while in EXEC SHALL be ignored with no effect on operands, counter or outputs.
REQ-016 All arithmetic SHALL use one shared W-bit adder instance (sum, carry-in, carry-out); no other adder or multiplier.
REQ-017 ADD: one EXEC cycle; result = zero-extended {cout, a+b}; cflag = carry-out.
REQ-018 SUB: one EXEC cycle; adder fed a, ~b, carry-in 1; result = zero-extended low W bits; cflag = NOT carry-out (borrow).
REQ-019 PASSA: one EXEC cycle; result = zero-extended a; cflag = 0.
REQ-020 MUL: W EXEC cycles, shift-and-add; working register {hi[W], lo[W]} init {0, b}; each cycle, if lo[0]=1, hi <= hi + a via shared adder, then {carry, hi, lo} shifted right one bit; after W cycles result = {hi, lo} = a*b unsigned.
REQ-021 An iteration counter of ceil(log2(W+1)) bits SHALL count MUL cycles; EXEC exits when it reaches W-1 (MUL) or after first cycle (others).
REQ-022 Latency: accept at edge N; done=1 in the cycle following edge N+1 (ADD/SUB/PASSA) or edge N+W (MUL).
REQ-023 result, cflag, zflag SHALL update on the edge entering DONE and SHALL NOT change during EXEC.
REQ-024 DONE lasts one cycle; without start it returns to IDLE; with start it re-enters EXEC (back-to-back, no bubble).
REQ-025 done SHALL be registered and high only in DONE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0, cflag=0, zflag=0, counter and operand registers 0.
REQ-027 rst asserted mid-EXEC SHALL abort the operation with no done pulse; after release, first start behaves as from power-up.
REQ-028 start sampled in the first clk after rst release SHALL be accepted normally.

Structure
REQ-029 Op codes, FSM state encoding and default W SHALL live in the shared package ula_pkg.
REQ-030 The shared adder SHALL be a separate sub-module ula_add4 (W-bit, parameterised, ports a, b, cin, sum, cout); FSM, counter and shift register stay in ula_mult_seq.

Verification (W=4)
REQ-031 MUL a=15 b=15: busy high 4 cycles, done one cycle later, result=0xE1, cflag=0, zflag=0.
REQ-032 ADD a=9 b=8: done 1 cycle after accept, result=0x11, cflag=1; SUB a=3 b=5: result=0x0E, cflag=1.
REQ-033 MUL a=7 b=0: result=0x00, zflag=1; PASSA a=0xA: result=0x0A, cflag=0.
REQ-034 MUL 3*5 then start (ADD 1+1) asserted during EXEC: ignored, result=0x0F; start held in DONE: ADD accepted back-to-back, result=0x02.
REQ-035 rst pulsed during MUL cycle 2: all outputs 0 immediately, no done pulse; next MUL 2*6 yields result=0x0C.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU/multiplier: op codes, FSM encoding, default width.
package ula_pkg;

    localparam int unsigned W_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_MUL   = 2'b10,
        OP_PASSA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ula_mult_seq_if.sv
// Request/response bundle of ula_mult_seq; master issues operations, slave executes them.
interface ula_mult_seq_if
    import ula_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic             start;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             cflag;
    logic             zflag;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cflag, zflag
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cflag, zflag
    );
endinterface

// File: rtl/ula_add4.sv
// W-bit ripple adder with carry-in/out; the single arithmetic resource of the datapath.
module ula_add4
    import ula_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int unsigned SW = W + 1;

    assign {cout, sum} = SW'(a) + SW'(b) + SW'(cin);
endmodule

// File: rtl/ula_mult_seq.sv
// Sequential ALU: single-cycle ADD/SUB/PASSA and W-cycle shift-and-add MUL over one shared adder.
module ula_mult_seq
    import ula_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    ula_mult_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned RW = 2 * W;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cflag_q, cflag_d;
    logic            zflag_q, zflag_d;

    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cin, add_cout;
    logic [W-1:0]    step_s;
    logic            step_c;
    logic [RW-1:0]   res_c;
    logic            res_cf_c;

    ula_add4 #(.W(W)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand steering; MUL accumulates a into the high half
    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_cin = 1'b0;
        case (op_q)
            OP_SUB: begin
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            OP_MUL: begin
                add_a = hi_q;
                add_b = a_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cflag_d  = cflag_q;
        zflag_d  = zflag_q;
        step_s   = hi_q;
        step_c   = 1'b0;
        res_c    = '0;
        res_cf_c = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_EXEC;
                    op_d    = op_e'(bus.op);
                    a_d     = bus.a;
                    b_d     = bus.b;
                    hi_d    = '0;
                    lo_d    = bus.b;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        res_c    = RW'({add_cout, add_sum});
                        res_cf_c = add_cout;
                        state_d  = S_DONE;
                    end
                    OP_SUB: begin
                        res_c    = RW'(add_sum);
                        res_cf_c = ~add_cout;
                        state_d  = S_DONE;
                    end
                    OP_PASSA: begin
                        res_c   = RW'(a_q);
                        state_d = S_DONE;
                    end
                    default: begin
                        // Conditional add, then shift {carry, hi, lo} right by one
                        if (lo_q[0]) begin
                            step_s = add_sum;
                            step_c = add_cout;
                        end
                        hi_d  = {step_c, step_s[W-1:1]};
                        lo_d  = {step_s[0], lo_q[W-1:1]};
                        res_c = {hi_d, lo_d};
                        if (cnt_q == CW'(W - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
                if (state_d == S_DONE) begin
                    result_d = res_c;
                    cflag_d  = res_cf_c;
                    zflag_d  = (res_c == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_EXEC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cflag_q  <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cflag_q  <= cflag_d;
            zflag_q  <= zflag_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cflag  = cflag_q;
    assign bus.zflag  = zflag_q;
endmodule

// File: tb/tb_ula_mult_seq.sv
// Directed vector bench for ula_mult_seq at W=4, plus back-to-back and mid-operation reset sequences.
module tb_ula_mult_seq;
    import ula_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs [12];

    ula_mult_seq_if #(.W(W)) bus ();

    ula_mult_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one op at a negedge, wait (bounded) for done, check timing and outputs
    task automatic run_op(input vec_t v, input string nm);
        logic [7:0] prev;
        int         cyc;
        int         bcyc;
        logic       stable;
        prev       = bus.result;
        bus.start  = 1'b1;
        bus.op     = v.op;
        bus.a      = v.a;
        bus.b      = v.b;
        @(negedge clk);
        bus.start  = 1'b0;
        cyc        = 0;
        bcyc       = 0;
        stable     = 1'b1;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) bcyc++;
            if (bus.result !== prev) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({nm, " done"}, 32'(bus.done), 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'(v.lat));
        check({nm, " busy cycles"}, 32'(bcyc), 32'(v.lat));
        check({nm, " result held in exec"}, 32'(stable), 32'd1);
        check({nm, " result"}, 32'(bus.result), 32'(v.res));
        check({nm, " cflag"}, 32'(bus.cflag), 32'(v.c));
        check({nm, " zflag"}, 32'(bus.zflag), 32'(v.z));
        check({nm, " busy at done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({nm, " done pulse width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   dn;
        vec_t v;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{OP_ADD,   4'd9,  4'd8,  8'h11, 1'b1, 1'b0, 1};
        vecs[1]  = '{OP_SUB,   4'd3,  4'd5,  8'h0E, 1'b1, 1'b0, 1};
        vecs[2]  = '{OP_MUL,   4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 4};
        vecs[3]  = '{OP_MUL,   4'd7,  4'd0,  8'h00, 1'b0, 1'b1, 4};
        vecs[4]  = '{OP_PASSA, 4'hA,  4'd3,  8'h0A, 1'b0, 1'b0, 1};
        vecs[5]  = '{OP_ADD,   4'd0,  4'd0,  8'h00, 1'b0, 1'b1, 1};
        vecs[6]  = '{OP_SUB,   4'd5,  4'd5,  8'h00, 1'b0, 1'b1, 1};
        vecs[7]  = '{OP_ADD,   4'd15, 4'd15, 8'h1E, 1'b1, 1'b0, 1};
        vecs[8]  = '{OP_SUB,   4'd0,  4'd1,  8'h0F, 1'b1, 1'b0, 1};
        vecs[9]  = '{OP_SUB,   4'd9,  4'd2,  8'h07, 1'b0, 1'b0, 1};
        vecs[10] = '{OP_MUL,   4'd9,  4'd13, 8'h75, 1'b0, 1'b0, 4};
        vecs[11] = '{OP_PASSA, 4'd0,  4'd15, 8'h00, 1'b0, 1'b1, 1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset done",   32'(bus.done),   32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset cflag",  32'(bus.cflag),  32'd0);
        check("reset zflag",  32'(bus.zflag),  32'd0);

        // First vector is requested in the very first cycle after reset release
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // MUL 3*5 with ADD 1+1 requested throughout EXEC and held into DONE
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 4'd3;
        bus.b     = 4'd5;
        @(negedge clk);
        bus.op    = OP_ADD;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        cyc       = 0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b mul done",    32'(bus.done),   32'd1);
        check("b2b mul latency", 32'(cyc),        32'd4);
        check("b2b mul result",  32'(bus.result), 32'h0F);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b add busy",    32'(bus.busy),   32'd1);
        check("b2b add no done", 32'(bus.done),   32'd0);
        check("b2b held result", 32'(bus.result), 32'h0F);
        @(negedge clk);
        check("b2b add done",    32'(bus.done),   32'd1);
        check("b2b add result",  32'(bus.result), 32'h02);
        check("b2b add cflag",   32'(bus.cflag),  32'd0);
        @(negedge clk);
        check("b2b idle done",   32'(bus.done),   32'd0);

        // Reset in the second MUL cycle aborts with all outputs cleared
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy",   32'(bus.busy),   32'd0);
        check("abort done",   32'(bus.done),   32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        check("abort cflag",  32'(bus.cflag),  32'd0);
        check("abort zflag",  32'(bus.zflag),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        check("abort no done pulse", 32'(dn), 32'd0);
        v = '{OP_MUL, 4'd2, 4'd6, 8'h0C, 1'b0, 1'b0, 4};
        run_op(v, "post-abort mul");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
